// File: rtl/imem_arb_pkg.sv
// Package: imem_arb_pkg
// Shared types and constants for the instruction-memory port arbiter.
//   owner_e  : owner of the previous cycle's BRAM access. This is the state
//              of the arbiter's response FSM.
//   NOP_INSN : canonical RISC-V NOP (addi x0,x0,0), for fetch-side consumers.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    F_RD = 2'd1,
    L_RD = 2'd2,
    L_WR = 2'd3
  } owner_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/imem_port_arbiter.sv
// Module: imem_port_arbiter
// Shares one single-port, 1-cycle-read instruction BRAM between the fetch
// stage (read-only) and a loader/debug port (read/write).
// - At most one access is granted per cycle.
// - Read data returns with a fixed 1-cycle latency.
// - Fetch starvation is bounded to BURST_MAX consecutive loader grants.
//
// Optional feature macro: IMEM_ARB_LOCK_EN
//   When defined, this module adds the ports l_lock (in) and f_locked (out).
//   While the registered lock is high, fetch is never granted.
//
// Ports
//   clk, rst_n             clock; asynchronous active-low reset
//   f_req/f_addr           fetch read request (held until f_gnt)
//   f_gnt                  fetch accepted this cycle
//   f_rvalid/f_rdata       fetch response, 1 cycle after f_gnt
//   l_req/l_we/l_addr/l_wdata  loader request (held until l_gnt)
//   l_gnt                  loader accepted this cycle
//   l_rvalid/l_rdata       loader read response, 1 cycle after a read grant
//   mem_en/mem_we/mem_addr/mem_wdata  BRAM drive, follows the granted port
//   mem_rdata              BRAM read data (write-first, 1-cycle read)
//   l_lock, f_locked       only with IMEM_ARB_LOCK_EN
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_MAX  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [DATA_WIDTH-1:0] f_rdata,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [DATA_WIDTH-1:0] l_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
`ifdef IMEM_ARB_LOCK_EN
  input  logic                  l_lock,
  output logic                  f_locked,
`endif
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_SAT = BW'(BURST_MAX);

  owner_e          state_reg, state_next;
  logic [BW-1:0]   burst_cnt_reg, burst_cnt_next;
  logic            lock_reg;
  logic            burst_sat;

  // Fetch lock: the request is registered so that the lock takes effect one
  // cycle after l_lock rises.
`ifdef IMEM_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_reg <= 1'b0;
    else        lock_reg <= l_lock;
  end
  assign f_locked = lock_reg;
`else
  assign lock_reg = 1'b0;
`endif

  // Arbitration. The grants are gated by rst_n, so every output reads 0
  // while reset is asserted, even if a requester keeps its request high.
  // On a tie the loader wins, unless it has already taken BURST_MAX grants
  // in a row while fetch was waiting.
  assign burst_sat = (burst_cnt_reg == BURST_SAT);
  assign f_gnt = rst_n & f_req & ~lock_reg & (~l_req | burst_sat);
  assign l_gnt = rst_n & l_req & ~f_gnt;

  // The BRAM drive follows the winner in the same cycle.
  // When no port is granted, the drive is all zeros.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (f_gnt) begin
      mem_en   = 1'b1;
      mem_addr = f_addr;
    end else if (l_gnt) begin
      mem_en    = 1'b1;
      mem_we    = l_we;
      mem_addr  = l_addr;
      mem_wdata = l_we ? l_wdata : '0;
    end
  end

  // Starvation counter. It counts loader grants taken while fetch is waiting,
  // and is only meaningful while fetch is actually requesting.
  always_comb begin
    burst_cnt_next = burst_cnt_reg;
    if (lock_reg || !f_req || f_gnt)
      burst_cnt_next = '0;
    else if (l_gnt && !burst_sat)
      burst_cnt_next = burst_cnt_reg + 1'b1;
  end

  // The response FSM remembers who owned the previous cycle's access.
  always_comb begin
    state_next = IDLE;
    if (f_gnt)             state_next = F_RD;
    else if (l_gnt &&  l_we) state_next = L_WR;
    else if (l_gnt && !l_we) state_next = L_RD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  assign f_rvalid = (state_reg == F_RD);
  assign l_rvalid = (state_reg == L_RD);
  assign f_rdata  = f_rvalid ? mem_rdata : '0;
  assign l_rdata  = l_rvalid ? mem_rdata : '0;

  // Both ports must never be granted in the same cycle.
  a_one_grant : assert property (@(posedge clk) disable iff (!rst_n) !(f_gnt && l_gnt));

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Testbench: tb_imem_port_arbiter
// Drives imem_port_arbiter against a 1-cycle write-first BRAM model that is
// preloaded with mem[i] = i. A scoreboard queues the expected read data
// whenever a grant is seen, and compares it when the matching rvalid arrives.
// Optional feature macro: IMEM_ARB_LOCK_EN (enables the lock scenario).
`timescale 1ns/1ps
module tb_imem_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          f_req, l_req, l_we;
  logic [AW-1:0] f_addr, l_addr;
  logic [DW-1:0] l_wdata;
  logic          f_gnt, f_rvalid, l_gnt, l_rvalid;
  logic [DW-1:0] f_rdata, l_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef IMEM_ARB_LOCK_EN
  logic          l_lock, f_locked;
`endif

  imem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef IMEM_ARB_LOCK_EN
    .l_lock(l_lock), .f_locked(f_locked),
`endif
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // BRAM model: 1-cycle read, write-first.
  logic [DW-1:0] bram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        bram[mem_addr] <= mem_wdata;
        mem_rdata      <= mem_wdata;
      end else begin
        mem_rdata <= bram[mem_addr];
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Bench-side reference memory, plus the scoreboard queues.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] fq[$];
  logic [DW-1:0] lq[$];
  bit f_pend = 1'b0;
  bit l_pend = 1'b0;

  // Monitor: samples on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      fq.delete(); lq.delete();
      f_pend = 1'b0; l_pend = 1'b0;
    end else begin
      check("f_rvalid", {31'd0, f_rvalid}, {31'd0, f_pend});
      check("l_rvalid", {31'd0, l_rvalid}, {31'd0, l_pend});
      if (f_rvalid) begin
        if (fq.size() > 0) check("f_rdata", f_rdata, fq.pop_front());
        else               check("f_rdata_unexpected", 32'd1, 32'd0);
      end else check("f_rdata_idle", f_rdata, 32'd0);
      if (l_rvalid) begin
        if (lq.size() > 0) check("l_rdata", l_rdata, lq.pop_front());
        else               check("l_rdata_unexpected", 32'd1, 32'd0);
      end else check("l_rdata_idle", l_rdata, 32'd0);

      if (f_gnt) begin
        check("mem_drive_f", {mem_en, mem_we, 20'd0, mem_addr}, {1'b1, 1'b0, 20'd0, f_addr});
        fq.push_back(ref_mem[f_addr]);
      end else if (l_gnt) begin
        check("mem_drive_l", {mem_en, mem_we, 20'd0, mem_addr}, {1'b1, l_we, 20'd0, l_addr});
        if (l_we) begin
          check("mem_wdata", mem_wdata, l_wdata);
          ref_mem[l_addr] = l_wdata;
        end else lq.push_back(ref_mem[l_addr]);
      end else begin
        check("mem_idle", {mem_en, mem_we, 20'd0, mem_addr}, 32'd0);
        check("mem_wdata_idle", mem_wdata, 32'd0);
      end
      f_pend = f_gnt;
      l_pend = l_gnt & ~l_we;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},    {30'd0, f_gnt, l_gnt}, 32'd0);
    check({tag, "_rvalid"}, {30'd0, f_rvalid, l_rvalid}, 32'd0);
    check({tag, "_f_rdata"}, f_rdata, 32'd0);
    check({tag, "_l_rdata"}, l_rdata, 32'd0);
    check({tag, "_mem"},    {mem_en, mem_we, 20'd0, mem_addr}, 32'd0);
    check({tag, "_wdata"},  mem_wdata, 32'd0);
  endtask

  int waited;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      bram[i]    = DW'(i);
      ref_mem[i] = DW'(i);
    end
    rst_n = 1'b0; f_req = 0; l_req = 0; l_we = 0;
    f_addr = '0; l_addr = '0; l_wdata = '0;
`ifdef IMEM_ARB_LOCK_EN
    l_lock = 1'b0;
`endif
    @(negedge clk);
    check_all_zero("reset");
    step();
    rst_n = 1'b1;

    // Idle: the memory stays disabled and no response appears.
    repeat (3) begin
      @(negedge clk);
      check("idle_en", {31'd0, mem_en}, 32'd0);
      check("idle_rvalid", {30'd0, f_rvalid, l_rvalid}, 32'd0);
    end
    step();

    // Back-to-back fetch reads of addresses 5, 6, 7.
    f_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      f_addr = AW'(5 + i);
      @(negedge clk);
      check("t1_f_gnt", {31'd0, f_gnt}, 32'd1);
      if (i > 0) check("t1_data", f_rdata, DW'(4 + i));
      step();
    end
    f_req = 1'b0;
    @(negedge clk);
    check("t1_data_last", f_rdata, 32'd7);
    step();

    // Loader write, then a fetch read of the same address.
    l_req = 1'b1; l_we = 1'b1; l_addr = AW'(3); l_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("t2_l_gnt", {31'd0, l_gnt}, 32'd1);
    step();
    l_req = 1'b0; l_we = 1'b0;
    f_req = 1'b1; f_addr = AW'(3);
    @(negedge clk);
    check("t2_f_gnt", {31'd0, f_gnt}, 32'd1);
    step();
    f_req = 1'b0;
    @(negedge clk);
    check("t2_raw_data", f_rdata, 32'hDEADBEEF);
    step();

    // Loader read of address 9.
    l_req = 1'b1; l_addr = AW'(9);
    @(negedge clk);
    check("t2b_l_gnt", {31'd0, l_gnt}, 32'd1);
    step();
    l_req = 1'b0;
    @(negedge clk);
    check("t2b_l_rdata", l_rdata, 32'd9);
    step();

    // Sustained contention: the grant pattern should be L,L,L,L,F repeating.
    f_req = 1'b1; f_addr = AW'(20); l_req = 1'b1; l_addr = AW'(30);
    waited = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("t3_l_gnt", {31'd0, l_gnt}, {31'd0, ((i % 5) != 4)});
      check("t3_f_gnt", {31'd0, f_gnt}, {31'd0, ((i % 5) == 4)});
      if (f_gnt) waited = 0; else waited++;
      check("t3_wait_bound", {31'd0, (waited > 4)}, 32'd0);
      step();
    end
    f_req = 1'b0; l_req = 1'b0;
    step();

    // Reset in the middle of a loader burst: the burst count must clear.
    f_req = 1'b1; l_req = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("t4_pre_l_gnt", {31'd0, l_gnt}, 32'd1);
      step();
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("t4_burst_rst");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_post_l_gnt", {31'd0, l_gnt}, {31'd0, (i != 4)});
      check("t4_post_f_gnt", {31'd0, f_gnt}, {31'd0, (i == 4)});
      step();
    end
    l_req = 1'b0;

    // Reset during a fetch response: the response must be dropped.
    f_addr = AW'(11);
    @(negedge clk);
    check("t4_f_gnt", {31'd0, f_gnt}, 32'd1);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("t4_frd_rst");
    step();
    rst_n = 1'b1;
    f_req = 1'b0;
    @(negedge clk);
    check("t4_no_rvalid", {30'd0, f_rvalid, l_rvalid}, 32'd0);
    step();

`ifdef IMEM_ARB_LOCK_EN
    // Lock: fetch is shut out while the registered lock is high.
    l_lock = 1'b1;
    step();
    f_req = 1'b1; f_addr = AW'(40); l_req = 1'b1; l_addr = AW'(41);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_f_gnt", {31'd0, f_gnt}, 32'd0);
      check("t5_locked", {31'd0, f_locked}, 32'd1);
      step();
    end
    l_lock = 1'b0; l_req = 1'b0;
    step();
    @(negedge clk);
    check("t5_unlock_f_gnt", {31'd0, f_gnt}, 32'd1);
    check("t5_unlocked", {31'd0, f_locked}, 32'd0);
    step();
    f_req = 1'b0;
`endif

    // Idle at the end: the response stream drains, and then nothing happens.
    step();
    repeat (3) begin
      @(negedge clk);
      check("t6_idle", {29'd0, mem_en, f_rvalid, l_rvalid}, 32'd0);
    end
    check("sb_f_drained", fq.size(), 32'd0);
    check("sb_l_drained", lq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
